// File: rtl/kmeans_pkg.sv
// Shared widths, divider timing and FSM state type for the k-means centroid
// update block.
package kmeans_pkg;

   localparam int COORD_W     = 32;
   localparam int SUM_W       = 48;
   localparam int CNT_W       = 32;
   localparam int DIV_CYCLES  = 48;
   // one slot = load + DIV_CYCLES divide iterations + writeback
   localparam int SLOT_CYCLES = DIV_CYCLES + 2;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DIV   = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider: one quotient bit per cycle for DIV_CYCLES cycles
// after i_start; o_done holds high from completion until the next start.
module serial_divider
   import kmeans_pkg::*;
#(
   parameter int DVD_W = SUM_W,
   parameter int DVS_W = CNT_W,
   parameter int Q_W   = COORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [DVD_W-1:0] i_dividend,
   input  logic [DVS_W-1:0] i_divisor,
   output logic [Q_W-1:0]   o_quotient,
   output logic             o_done
);

   localparam int IW = $clog2(DIV_CYCLES + 1);

   logic [DVS_W-1:0] r_rem;
   logic [DVD_W-1:0] r_quo;
   logic [DVS_W-1:0] r_dvs;
   logic [IW-1:0]    r_iter;
   logic             r_run;
   logic             r_done;

   logic [DVS_W:0]   w_shift;
   logic             w_ge;
   logic [DVS_W-1:0] w_diff;

   // remainder stays below the divisor, so the shifted value fits in DVS_W+1
   assign w_shift = {r_rem, r_quo[DVD_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift[DVS_W-1:0] - r_dvs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_iter <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else if (i_start) begin
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_dvs  <= i_divisor;
         r_iter <= IW'(DIV_CYCLES);
         r_run  <= 1'b1;
         r_done <= 1'b0;
      end else if (r_run) begin
         r_rem  <= w_ge ? w_diff : w_shift[DVS_W-1:0];
         r_quo  <= {r_quo[DVD_W-2:0], w_ge};
         r_iter <= r_iter - IW'(1);
         if (r_iter == IW'(1)) begin
            r_run  <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign o_quotient = r_quo[Q_W-1:0];
   assign o_done     = r_done;

endmodule

// File: rtl/centroid_update.sv
// Accumulates classified points per class, then serially divides sum/count
// into the centroid table. Define KMEANS_ROUND_EN for round-to-nearest quotients.
module centroid_update
   import kmeans_pkg::*;
#(
   parameter int n = 8,
   parameter int d = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [d-1:0][COORD_W-1:0]            point,
   input  logic [31:0]                          id_class,
   input  logic                                 epoch_end,
   output logic [2**n-1:0][d-1:0][COORD_W-1:0]  centroids,
   output logic                                 busy,
   output logic                                 out_valid
);

   localparam int NC    = 2**n;
   localparam int DW    = (d > 1) ? $clog2(d) : 1;
   localparam int CYC_W = $clog2(SLOT_CYCLES);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);

   state_t r_state, w_next;

   logic [CYC_W-1:0] r_cyc;
   logic [n-1:0]     r_cls;
   logic [DW-1:0]    r_dim;

   logic [NC-1:0][d-1:0][SUM_W-1:0]   r_sum;
   logic [NC-1:0][CNT_W-1:0]          r_cnt;
   logic [NC-1:0][d-1:0][COORD_W-1:0] r_cent;

   logic               w_acc;
   logic               w_load;
   logic               w_wb;
   logic               w_dim_last;
   logic               w_last_slot;
   logic [n-1:0]       w_cls_in;
   logic [SUM_W-1:0]   w_dividend;
   logic [CNT_W-1:0]   w_divisor;
   logic [COORD_W-1:0] w_quo;
   logic               w_div_done;

   assign w_cls_in    = id_class[n-1:0];
   assign w_acc       = in_valid && in_ready;
   assign w_load      = (r_state == DIV) && (r_cyc == '0);
   assign w_wb        = (r_state == DIV) && (r_cyc == CYC_LAST);
   assign w_dim_last  = (r_dim == DW'(d - 1));
   assign w_last_slot = w_wb && w_dim_last && (r_cls == {n{1'b1}});

   if (n < 32) begin : g_unused
      logic w_unused_cls;
      assign w_unused_cls = ^id_class[31:n];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      case (r_state)
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (epoch_end) w_next = DIV;
         end
         DIV: begin
            if (w_last_slot) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            w_next    = ACCUM;
         end
         default: w_next = ACCUM;
      endcase
   end

   // slot walker: class-major, dimension-minor, SLOT_CYCLES per slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc <= '0;
         r_cls <= '0;
         r_dim <= '0;
      end else if (r_state != DIV) begin
         r_cyc <= '0;
         r_cls <= '0;
         r_dim <= '0;
      end else if (w_wb) begin
         r_cyc <= '0;
         if (w_dim_last) begin
            r_dim <= '0;
            r_cls <= r_cls + n'(1);
         end else begin
            r_dim <= r_dim + DW'(1);
         end
      end else begin
         r_cyc <= r_cyc + CYC_W'(1);
      end
   end

`ifdef KMEANS_ROUND_EN
   assign w_dividend = r_sum[r_cls][r_dim] + SUM_W'(r_cnt[r_cls] >> 1);
`else
   assign w_dividend = r_sum[r_cls][r_dim];
`endif
   assign w_divisor = r_cnt[r_cls];

   serial_divider #(
      .DVD_W (SUM_W),
      .DVS_W (CNT_W),
      .Q_W   (COORD_W)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_load),
      .i_dividend (w_dividend),
      .i_divisor  (w_divisor),
      .o_quotient (w_quo),
      .o_done     (w_div_done)
   );

   // accumulation only happens in ACCUM and writeback only in DIV, so the two never collide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum  <= '0;
         r_cnt  <= '0;
         r_cent <= '0;
      end else begin
         if (w_acc) begin
            for (int j = 0; j < d; j++)
               r_sum[w_cls_in][j] <= r_sum[w_cls_in][j] + SUM_W'(point[j]);
            r_cnt[w_cls_in] <= r_cnt[w_cls_in] + CNT_W'(1);
         end
         if (w_wb) begin
            if ((r_cnt[r_cls] != '0) && w_div_done)
               r_cent[r_cls][r_dim] <= w_quo;
            r_sum[r_cls][r_dim] <= '0;
            if (w_dim_last) r_cnt[r_cls] <= '0;
         end
      end
   end

   assign centroids = r_cent;

endmodule

// File: tb/tb_centroid_update.sv
// Self-checking bench for centroid_update: n=1,d=2 main instance plus an n=2
// instance for class-index masking and longer latency.
module tb_centroid_update;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                  in_valid, in_ready, epoch_end, busy, out_valid;
   logic [1:0][31:0]      point;
   logic [31:0]           id_class;
   logic [1:0][1:0][31:0] centroids;

   logic                  in_valid2, in_ready2, epoch_end2, busy2, out_valid2;
   logic [1:0][31:0]      point2;
   logic [31:0]           id_class2;
   logic [3:0][1:0][31:0] centroids2;

   int checks = 0;
   int errors = 0;

   longint unsigned m_sum  [2][2];
   longint unsigned m_cnt  [2];
   longint unsigned m_cent [2][2];

   centroid_update #(.n(1), .d(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .point(point), .id_class(id_class), .epoch_end(epoch_end),
      .centroids(centroids), .busy(busy), .out_valid(out_valid)
   );

   centroid_update #(.n(2), .d(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .point(point2), .id_class(id_class2), .epoch_end(epoch_end2),
      .centroids(centroids2), .busy(busy2), .out_valid(out_valid2)
   );

   // ---------------- reference model ----------------
   function automatic void model_clear_all();
      for (int c = 0; c < 2; c++) begin
         m_cnt[c] = 0;
         for (int j = 0; j < 2; j++) begin
            m_sum[c][j]  = 0;
            m_cent[c][j] = 0;
         end
      end
   endfunction

   function automatic void model_close();
      for (int c = 0; c < 2; c++) begin
         for (int j = 0; j < 2; j++) begin
            if (m_cnt[c] != 0) begin
`ifdef KMEANS_ROUND_EN
               m_cent[c][j] = ((m_sum[c][j] + m_cnt[c] / 2) / m_cnt[c]) & 64'hFFFF_FFFF;
`else
               m_cent[c][j] = (m_sum[c][j] / m_cnt[c]) & 64'hFFFF_FFFF;
`endif
            end
            m_sum[c][j] = 0;
         end
         m_cnt[c] = 0;
      end
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic drive_point(input int c, input logic [31:0] x, input logic [31:0] y);
      in_valid = 1'b1;
      id_class = ($urandom() & 32'hFFFF_FFFE) | 32'(c);
      point[0] = x;
      point[1] = y;
      @(negedge clk);
      in_valid = 1'b0;
      m_sum[c][0] += x;
      m_sum[c][1] += y;
      m_cnt[c]    += 1;
   endtask

   // k counts cycles after the edge that sampled epoch_end; returns -1 on timeout
   task automatic wait_out(input int k0, output int lat);
      lat = -1;
      for (int k = k0 + 1; k <= k0 + 600 && lat < 0; k++) begin
         @(negedge clk);
         epoch_end = 1'b0;
         in_valid  = 1'b0;
         if (out_valid === 1'b1) lat = k;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (centroids !== '0)   begin errors++; $display("FAIL reset_centroids got %h exp 0", centroids); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
      model_clear_all();
   endtask

   task automatic test_basic();
      int lat;
      drive_point(0, 10, 20);
      drive_point(0, 30, 40);
      drive_point(1, 5, 5);
      epoch_end = 1'b1;
      wait_out(0, lat);
      model_close();
      checks++; if (lat != 201) begin errors++; $display("FAIL basic_latency got %0d exp 201", lat); end
      for (int c = 0; c < 2; c++)
         for (int j = 0; j < 2; j++) begin
            checks++;
            if (centroids[c][j] !== 32'(m_cent[c][j])) begin
               errors++; $display("FAIL basic_cent[%0d][%0d] got %0d exp %0d", c, j, centroids[c][j], m_cent[c][j]);
            end
         end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_to_accum got %b exp 1", in_ready); end
   endtask

   task automatic test_empty_class();
      int lat;
      logic [31:0] exp00;
`ifdef KMEANS_ROUND_EN
      exp00 = 32'd2;
`else
      exp00 = 32'd1;
`endif
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      model_clear_all();
      drive_point(0, 1, 0);
      drive_point(0, 2, 0);
      epoch_end = 1'b1;
      wait_out(0, lat);
      checks++; if (lat != 201) begin errors++; $display("FAIL empty_latency got %0d exp 201", lat); end
      checks++; if (centroids[0][0] !== exp00) begin errors++; $display("FAIL empty_rounding got %0d exp %0d", centroids[0][0], exp00); end
      checks++; if (centroids[0][1] !== 32'd0) begin errors++; $display("FAIL empty_zero_dim got %0d exp 0", centroids[0][1]); end
      checks++; if (centroids[1] !== '0) begin errors++; $display("FAIL empty_class_unchanged got %h exp 0", centroids[1]); end
      model_close();
      @(negedge clk);
   endtask

   task automatic test_epoch_edge();
      int lat;
      // point arrives together with epoch_end and must be counted
      epoch_end = 1'b1;
      in_valid  = 1'b1;
      id_class  = 32'd1;
      point[0]  = 32'd7;
      point[1]  = 32'd9;
      m_sum[1][0] += 7; m_sum[1][1] += 9; m_cnt[1] += 1;
      @(negedge clk);
      epoch_end = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL edge_in_ready got %b exp 0", in_ready); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL edge_busy got %b exp 1", busy); end
      // offered during DIV: must be ignored
      point[0] = 32'd1000;
      point[1] = 32'd1000;
      repeat (4) @(negedge clk);
      wait_out(5, lat);
      model_close();
      checks++; if (lat != 201) begin errors++; $display("FAIL edge_latency got %0d exp 201", lat); end
      for (int j = 0; j < 2; j++) begin
         checks++;
         if (centroids[1][j] !== 32'(m_cent[1][j])) begin
            errors++; $display("FAIL edge_cent[1][%0d] got %0d exp %0d", j, centroids[1][j], m_cent[1][j]);
         end
      end
      @(negedge clk);
      drive_point(1, 2, 2);
      epoch_end = 1'b1;
      wait_out(0, lat);
      model_close();
      for (int j = 0; j < 2; j++) begin
         checks++;
         if (centroids[1][j] !== 32'(m_cent[1][j])) begin
            errors++; $display("FAIL edge_followup_cent[1][%0d] got %0d exp %0d", j, centroids[1][j], m_cent[1][j]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      int lat;
      int seen;
      drive_point(0, 100, 200);
      epoch_end = 1'b1;
      seen = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         epoch_end = 1'b0;
         if (out_valid === 1'b1) seen++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (centroids !== '0)   begin errors++; $display("FAIL middiv_centroids got %h exp 0", centroids); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middiv_out_valid got %b exp 0", out_valid); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL middiv_in_ready got %b exp 1", in_ready); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL middiv_busy got %b exp 0", busy); end
      for (int k = 0; k < 250; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1 || centroids !== '0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL middiv_no_result got %0d events exp 0", seen); end
      model_clear_all();
      drive_point(1, 40, 60);
      drive_point(1, 20, 20);
      epoch_end = 1'b1;
      wait_out(0, lat);
      model_close();
      checks++; if (lat != 201) begin errors++; $display("FAIL middiv_latency got %0d exp 201", lat); end
      for (int c = 0; c < 2; c++)
         for (int j = 0; j < 2; j++) begin
            checks++;
            if (centroids[c][j] !== 32'(m_cent[c][j])) begin
               errors++; $display("FAIL middiv_cent[%0d][%0d] got %0d exp %0d", c, j, centroids[c][j], m_cent[c][j]);
            end
         end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int e = 0; e < 3; e++) begin
         int np;
         np = $urandom_range(1, 6);
         for (int p = 0; p < np; p++) begin
            drive_point($urandom_range(0, 1), $urandom(), $urandom());
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         epoch_end = 1'b1;
         wait_out(0, lat);
         model_close();
         checks++; if (lat != 201) begin errors++; $display("FAIL b2b_latency epoch %0d got %0d exp 201", e, lat); end
         for (int c = 0; c < 2; c++)
            for (int j = 0; j < 2; j++) begin
               checks++;
               if (centroids[c][j] !== 32'(m_cent[c][j])) begin
                  errors++; $display("FAIL b2b_cent epoch %0d [%0d][%0d] got %0d exp %0d", e, c, j, centroids[c][j], m_cent[c][j]);
               end
            end
         @(negedge clk);
      end
   endtask

   task automatic test_n2();
      int lat;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL n2_in_ready got %b exp 1", in_ready2); end
      in_valid2 = 1'b1;
      id_class2 = 32'hFFFF_FFF1;
      point2[0] = 32'd8;
      point2[1] = 32'd8;
      @(negedge clk);
      in_valid2  = 1'b0;
      epoch_end2 = 1'b1;
      lat = -1;
      for (int k = 1; k <= 600 && lat < 0; k++) begin
         @(negedge clk);
         epoch_end2 = 1'b0;
         if (k == 1) begin
            checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL n2_busy got %b exp 1", busy2); end
         end
         if (out_valid2 === 1'b1) lat = k;
      end
      checks++; if (lat != 401) begin errors++; $display("FAIL n2_latency got %0d exp 401", lat); end
      for (int c = 0; c < 4; c++)
         for (int j = 0; j < 2; j++) begin
            checks++;
            if (centroids2[c][j] !== ((c == 1) ? 32'd8 : 32'd0)) begin
               errors++; $display("FAIL n2_cent[%0d][%0d] got %0d exp %0d", c, j, centroids2[c][j], (c == 1) ? 8 : 0);
            end
         end
      @(negedge clk);
   endtask

   initial begin
      in_valid   = 1'b0;
      epoch_end  = 1'b0;
      point      = '0;
      id_class   = '0;
      in_valid2  = 1'b0;
      epoch_end2 = 1'b0;
      point2     = '0;
      id_class2  = '0;
      model_clear_all();
      test_reset();
      test_basic();
      test_empty_class();
      test_epoch_edge();
      test_reset_mid_div();
      test_back_to_back();
      test_n2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
